pingpong_feeder: RTL and testbench
==================================

PINGPONG_FEEDER -- requirements
Module: pingpong_feeder

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, bit width of each data bank.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_data  input  WIDTH  producer data word.
REQ-005 SHALL have port: in_valid  input  1  producer asserts in_data is valid.
REQ-006 SHALL have port: in_ready  output  1  feeder can accept in_data this cycle.
REQ-007 SHALL have port: d0  output  WIDTH  bank 0 contents, wired to downstream 2:1 mux d0.
REQ-008 SHALL have port: d1  output  WIDTH  bank 1 contents, wired to downstream 2:1 mux d1.
REQ-009 SHALL have port: s  output  1  read-bank select, wired to downstream mux s.
REQ-010 SHALL have port: out_valid  output  1  bank selected by s holds unread data.
REQ-011 SHALL have port: out_ready  input  1  consumer takes mux output y this cycle.

Function
REQ-012 SHALL keep per-bank full flags full[1:0], a write pointer wp, and read pointer s.
REQ-013 SHALL drive in_ready = !full[wp] combinationally; no dependency on in_valid.
REQ-014 SHALL, on in_valid && in_ready, load in_data into bank wp, set full[wp], toggle wp.
REQ-015 SHALL drive out_valid = full[s] combinationally.
REQ-016 SHALL, on out_valid && out_ready, clear full[s] and toggle s; bank data is kept, not cleared.
REQ-017 SHALL accept a write and a read in the same cycle when they target different banks; sustained throughput is one word per cycle.
REQ-018 SHALL leave bank contents, wp and full unchanged when in_valid is high and in_ready is low; in_data is ignored.
REQ-019 SHALL leave s and full unchanged when out_ready is high and out_valid is low.
REQ-020 SHALL make written data visible on d0/d1 one cycle after the accepting edge; out_valid rises in the same cycle, so write-to-read latency is 1 cycle.
REQ-021 SHALL deliver words in acceptance order, alternating bank 0 and bank 1.
REQ-022 SHALL hold d0, d1 and s stable while out_valid is high and out_ready is low.
REQ-023 SHALL report both banks full as in_ready=0 and both banks empty as out_valid=0.

Reset
REQ-024 SHALL, while reset is high, asynchronously force d0=0, d1=0, s=0, wp=0 and full=2'b00.
REQ-025 SHALL, while reset is high, present out_valid=0 and in_ready=1.
REQ-026 SHALL discard any in-flight data on reset mid-operation, and the first write after reset goes to bank 0.

Configuration
REQ-027 SHALL, with macro PINGPONG_FEEDER_XFER_CNT_EN defined, add output port xfer_count [7:0].
REQ-028 SHALL, when xfer_count is present, increment it on each out_valid && out_ready, wrap 255 to 0, and reset it to 0.
REQ-029 SHALL, without the macro, have neither the port nor the counter; all other behaviour is identical.

Structure
REQ-030 SHALL take the WIDTH default and the xfer_count width (8) from shared package pingpong_pkg.
REQ-031 SHALL implement each bank as sub-module pingpong_bank, two instances: a WIDTH-bit register with load enable plus full flag.
REQ-032 SHALL NOT contain the 2:1 mux; the existing structural mux consumes d0, d1 and s.

Verification
REQ-033 SHALL cover single word: write 4'b1010, out_ready=0 -> next cycle d0=1010, s=0, out_valid=1; assert out_ready -> s=1, out_valid=0.
REQ-034 SHALL cover fill both banks: writes 1010 then 0101, out_ready=0 -> in_ready=0; third word 1111 not stored; d0=1010, d1=0101.
REQ-035 SHALL cover streaming: in_valid and out_ready held high for words 1..8 -> mux y = 1..8 in order, one per cycle after 1-cycle latency, s toggling each cycle.
REQ-036 SHALL cover reset mid-operation: both banks full, assert reset -> d0=d1=0, s=0, out_valid=0, in_ready=1 immediately, before any clk edge.
REQ-037 SHALL cover the counter with PINGPONG_FEEDER_XFER_CNT_EN defined: 257 reads -> xfer_count=1; without the macro the bench compiles with no xfer_count port.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared constants for the ping-pong feeder: default bank width and transfer counter width.
package pingpong_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int XFER_CNT_W = 8;

endpackage

// File: rtl/pingpong_bank.sv
// One ping-pong bank: WIDTH-bit data register with load enable plus a full flag.
// Load sets full and captures din; clear drops full but keeps the stored data.
module pingpong_bank
  import pingpong_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

  // load and clear never coincide: a write needs the bank empty, a read needs it full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pingpong_feeder.sv
// Two-bank ping-pong feeder for an external 2:1 mux; 1-cycle write-to-read latency, 1 word/cycle.
// in_ready drops only when the write bank is full; optional xfer_count under PINGPONG_FEEDER_XFER_CNT_EN.
module pingpong_feeder
  import pingpong_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      d0,
  output logic [WIDTH-1:0]      d1,
  output logic                  s,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef PINGPONG_FEEDER_XFER_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_count
`endif
);

  logic [1:0] full;
  logic       wp;
  logic       wr_fire;
  logic       rd_fire;

  assign in_ready  = !full[wp];
  assign out_valid = full[s];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  pingpong_bank #(.WIDTH(WIDTH)) u_bank0 (
    .clk   (clk),
    .reset (reset),
    .load  (wr_fire && !wp),
    .clear (rd_fire && !s),
    .din   (in_data),
    .dout  (d0),
    .full  (full[0])
  );

  pingpong_bank #(.WIDTH(WIDTH)) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .load  (wr_fire && wp),
    .clear (rd_fire && s),
    .din   (in_data),
    .dout  (d1),
    .full  (full[1])
  );

  // Write and read pointers each flip after their own handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= 1'b0;
      s  <= 1'b0;
    end else begin
      if (wr_fire) wp <= ~wp;
      if (rd_fire) s  <= ~s;
    end
  end

`ifdef PINGPONG_FEEDER_XFER_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (rd_fire) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_feeder.sv
// Directed bench for pingpong_feeder; the downstream 2:1 mux is modelled locally as y.
// Define PINGPONG_FEEDER_XFER_CNT_EN to also exercise xfer_count.
module tb_pingpong_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] d0;
  logic [3:0] d1;
  logic       s;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
`ifdef PINGPONG_FEEDER_XFER_CNT_EN
  logic [7:0] xfer_count;
`endif

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  assign y = s ? d1 : d0;

  pingpong_feeder #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d0         (d0),
    .d1         (d1),
    .s          (s),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef PINGPONG_FEEDER_XFER_CNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    if (obs !== expv) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge, land 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 4'b0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_d0",        d0,        4'b0000);
    check("rst_d1",        d1,        4'b0000);
    check("rst_s",         s,         1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    reset = 1'b0;

    // Single word, then read it
    step();
    in_data  = 4'b1010;
    in_valid = 1'b1;
    check("single_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("single_d0",        d0,        4'b1010);
    check("single_s",         s,         1'b0);
    check("single_out_valid", out_valid, 1'b1);
    check("single_y",         y,         4'b1010);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_rd_s",         s,         1'b1);
    check("single_rd_out_valid", out_valid, 1'b0);
    check("single_d0_kept",      d0,        4'b1010);

    // Fill both banks, third word must be refused
    do_reset();
    step();
    in_data  = 4'b1010;
    in_valid = 1'b1;
    step();
    in_data  = 4'b0101;
    step();
    in_data  = 4'b1111;
    check("fill_in_ready", in_ready, 1'b0);
    step();
    check("fill_in_ready_held", in_ready,  1'b0);
    check("fill_d0",            d0,        4'b1010);
    check("fill_d1",            d1,        4'b0101);
    check("fill_s_held",        s,         1'b0);
    check("fill_out_valid",     out_valid, 1'b1);
    in_valid = 1'b0;

    // Asynchronous reset with both banks full, checked before any edge
    reset = 1'b1;
    #1;
    check("arst_d0",        d0,        4'b0000);
    check("arst_d1",        d1,        4'b0000);
    check("arst_s",         s,         1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    reset = 1'b0;
    step();
    in_data  = 4'b0011;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_d0", d0, 4'b0011);
    check("post_rst_d1", d1, 4'b0000);

    // Streaming words 1..8 with both handshakes held high
    do_reset();
    step();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 4'(k);
      step();
      check($sformatf("stream_y%0d", k),  y,         32'(k));
      check($sformatf("stream_s%0d", k),  s,         32'((k - 1) % 2));
      check($sformatf("stream_ov%0d", k), out_valid, 1'b1);
      check($sformatf("stream_ir%0d", k), in_ready,  1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_out_valid", out_valid, 1'b0);
    check("stream_drain_s",         s,         1'b0);
    step();
    check("idle_read_s",         s,         1'b0);
    check("idle_read_out_valid", out_valid, 1'b0);
    out_ready = 1'b0;

`ifdef PINGPONG_FEEDER_XFER_CNT_EN
    do_reset();
    check("cnt_rst", xfer_count, 8'd0);
    step();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      in_data = 4'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("cnt_wrap", xfer_count, 8'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
